// File: rtl/uart_ahb_master_if.sv
// AHB-Lite bus between the UART bridge master and the UART slave port.
// The master drives the address/control/write-data side; the slave answers
// with HREADY and read data.
interface uart_ahb_master_if;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HSEL;
   logic [31:0] HWDATA;

   modport master (
      input  HREADY, HRDATA,
      output HADDR, HTRANS, HWRITE, HSEL, HWDATA
   );

   modport slave (
      output HREADY, HRDATA,
      input  HADDR, HTRANS, HWRITE, HSEL, HWDATA
   );
endinterface

// File: rtl/uart_ahb_master.sv
// AHB-Lite master sitting directly in front of the UART slave port.
// TX bytes become single writes to the data register. An RX interrupt
// triggers a status read, and if the FIFO really holds data, a data read
// whose byte is presented on the RX stream. One transfer in flight at a time.
module uart_ahb_master #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [7:0]  DATA_OFF    = 8'h00,
   parameter logic [7:0]  STAT_OFF    = 8'h04,
   parameter int          STALL_LIMIT = 1024,
   parameter int          CNT_W       = 16
) (
   input  logic                 i_Clock,
   input  logic                 i_reset,
   uart_ahb_master_if.master    ahb,
   input  logic                 i_irq,
   input  logic                 i_tx_valid,
   input  logic [7:0]           i_tx_data,
   output logic                 o_tx_ready,
   output logic                 o_rx_valid,
   output logic [7:0]           o_rx_data,
   input  logic                 i_rx_ready,
   output logic [CNT_W-1:0]     o_tx_count,
   output logic [CNT_W-1:0]     o_rx_count,
   output logic [CNT_W-1:0]     o_spurious,
   output logic                 o_stall_err,
   output logic                 o_busy
);

   localparam logic [31:0] DATA_ADDR = BASE_ADDR + {24'h0, DATA_OFF};
   localparam logic [31:0] STAT_ADDR = BASE_ADDR + {24'h0, STAT_OFF};
   localparam logic [1:0]  TR_IDLE   = 2'b00;
   localparam logic [1:0]  TR_NSEQ   = 2'b10;
   localparam int          STALL_W   = $clog2(STALL_LIMIT + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_D,
      ST_A,
      ST_D,
      RD_A,
      RD_D
   } state_t;

   state_t             state;
   logic               last_rx;
   logic [7:0]         tx_byte;
   logic [STALL_W-1:0] stall_cnt;
   logic               rx_req;
   logic               tx_req;
   logic               rx_grant;
   logic               tx_grant;
   logic               hrdata_unused;

   // Only the low byte and the rx_empty flag of read data matter here.
   assign hrdata_unused = ^ahb.HRDATA[31:8];

   // Request arbitration: when both sides want the bus, whoever did not go last wins.
   always_comb begin
      rx_req   = i_irq & ~o_rx_valid;
      tx_req   = i_tx_valid;
      rx_grant = (state == IDLE) & rx_req & ~(tx_req & last_rx);
      tx_grant = (state == IDLE) & tx_req & ~(rx_req & ~last_rx);
   end

   assign o_tx_ready = tx_grant;
   assign o_busy     = (state != IDLE);

   // Sequencer: walks each bus sequence phase by phase and owns all registered outputs.
   always_ff @(posedge i_Clock) begin
      if (i_reset) begin
         state       <= IDLE;
         last_rx     <= 1'b0;
         tx_byte     <= 8'h00;
         ahb.HTRANS  <= TR_IDLE;
         ahb.HSEL    <= 1'b0;
         ahb.HWRITE  <= 1'b0;
         ahb.HADDR   <= 32'h0;
         ahb.HWDATA  <= 32'h0;
         o_rx_valid  <= 1'b0;
         o_rx_data   <= 8'h00;
         o_tx_count  <= '0;
         o_rx_count  <= '0;
         o_spurious  <= '0;
      end else begin
         if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (rx_grant) begin
                  state      <= ST_A;
                  last_rx    <= 1'b1;
                  ahb.HTRANS <= TR_NSEQ;
                  ahb.HSEL   <= 1'b1;
                  ahb.HWRITE <= 1'b0;
                  ahb.HADDR  <= STAT_ADDR;
               end else if (tx_grant) begin
                  state      <= WR_A;
                  last_rx    <= 1'b0;
                  tx_byte    <= i_tx_data;
                  ahb.HTRANS <= TR_NSEQ;
                  ahb.HSEL   <= 1'b1;
                  ahb.HWRITE <= 1'b1;
                  ahb.HADDR  <= DATA_ADDR;
               end
            end
            WR_A: begin
               if (ahb.HREADY) begin
                  state      <= WR_D;
                  ahb.HTRANS <= TR_IDLE;
                  ahb.HSEL   <= 1'b0;
                  ahb.HWDATA <= {24'h0, tx_byte};
               end
            end
            WR_D: begin
               if (ahb.HREADY) begin
                  state      <= IDLE;
                  o_tx_count <= o_tx_count + CNT_W'(1);
               end
            end
            ST_A: begin
               if (ahb.HREADY) begin
                  state      <= ST_D;
                  ahb.HTRANS <= TR_IDLE;
                  ahb.HSEL   <= 1'b0;
               end
            end
            ST_D: begin
               if (ahb.HREADY) begin
                  if (ahb.HRDATA[0]) begin
                     state      <= IDLE;
                     o_spurious <= o_spurious + CNT_W'(1);
                  end else begin
                     state      <= RD_A;
                     ahb.HTRANS <= TR_NSEQ;
                     ahb.HSEL   <= 1'b1;
                     ahb.HWRITE <= 1'b0;
                     ahb.HADDR  <= DATA_ADDR;
                  end
               end
            end
            RD_A: begin
               if (ahb.HREADY) begin
                  state      <= RD_D;
                  ahb.HTRANS <= TR_IDLE;
                  ahb.HSEL   <= 1'b0;
               end
            end
            RD_D: begin
               if (ahb.HREADY) begin
                  state      <= IDLE;
                  o_rx_data  <= ahb.HRDATA[7:0];
                  o_rx_valid <= 1'b1;
                  o_rx_count <= o_rx_count + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Stall watchdog: counts back-to-back wait states and latches a sticky error at the limit.
   always_ff @(posedge i_Clock) begin
      if (i_reset) begin
         stall_cnt   <= '0;
         o_stall_err <= 1'b0;
      end else if ((state != IDLE) && !ahb.HREADY) begin
         if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
         end
         if (stall_cnt == STALL_MAX - STALL_W'(1)) begin
            o_stall_err <= 1'b1;
         end
      end else begin
         stall_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_uart_ahb_master.sv
// Bench for uart_ahb_master: directed scenarios, a transfer-list model that
// predicts every output each cycle, and literal spot checks that pin the model.
// A second instance with a short stall limit shares all stimulus.
module tb_uart_ahb_master;

   localparam int P_WA = 0, P_WD = 1, P_SA = 2, P_SD = 3, P_RA = 4, P_RD = 5;

   logic        clk;
   logic        rst;
   logic        hready;
   logic [31:0] stat_word;
   logic [31:0] data_word;
   logic        irq;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        rx_ready;

   logic        tx_ready,   tx_ready_s;
   logic        rx_valid,   rx_valid_s;
   logic [7:0]  rx_data,    rx_data_s;
   logic [15:0] tx_count,   tx_count_s;
   logic [15:0] rx_count,   rx_count_s;
   logic [15:0] spurious,   spurious_s;
   logic        stall_err,  stall_err_s;
   logic        busy,       busy_s;

   int total  = 0;
   int passed = 0;

   uart_ahb_master_if ahb ();
   uart_ahb_master_if ahb_s ();

   // Slave side: read data depends on which register the last address phase selected.
   assign ahb.HREADY   = hready;
   assign ahb_s.HREADY = hready;
   assign ahb.HRDATA   = (ahb.HADDR == 32'h4)   ? stat_word : data_word;
   assign ahb_s.HRDATA = (ahb_s.HADDR == 32'h4) ? stat_word : data_word;

   uart_ahb_master dut (
      .i_Clock     (clk),
      .i_reset     (rst),
      .ahb         (ahb.master),
      .i_irq       (irq),
      .i_tx_valid  (tx_valid),
      .i_tx_data   (tx_data),
      .o_tx_ready  (tx_ready),
      .o_rx_valid  (rx_valid),
      .o_rx_data   (rx_data),
      .i_rx_ready  (rx_ready),
      .o_tx_count  (tx_count),
      .o_rx_count  (rx_count),
      .o_spurious  (spurious),
      .o_stall_err (stall_err),
      .o_busy      (busy)
   );

   uart_ahb_master #(.STALL_LIMIT(4)) dut_s (
      .i_Clock     (clk),
      .i_reset     (rst),
      .ahb         (ahb_s.master),
      .i_irq       (irq),
      .i_tx_valid  (tx_valid),
      .i_tx_data   (tx_data),
      .o_tx_ready  (tx_ready_s),
      .o_rx_valid  (rx_valid_s),
      .o_rx_data   (rx_data_s),
      .i_rx_ready  (rx_ready),
      .o_tx_count  (tx_count_s),
      .o_rx_count  (rx_count_s),
      .o_spurious  (spurious_s),
      .o_stall_err (stall_err_s),
      .o_busy      (busy_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act === exp) begin
         passed = passed + 1;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: pending bus phases of the current sequence plus observable results.
   int          m_q[$];
   bit          m_on = 1'b0;
   logic        m_last_rx, m_rx_valid, m_hwrite, m_err, m_err_s;
   logic [7:0]  m_rx_data, m_tx_byte;
   logic [31:0] m_haddr, m_hwdata;
   logic [15:0] m_tx_cnt, m_rx_cnt, m_spur;
   int          m_stall;

   // Model update on each rising edge from the inputs the DUT sees at that edge.
   always @(posedge clk) begin : model
      logic rv_next;
      logic rxr;
      logic txr;
      int   ph;
      if (rst) begin
         m_q.delete();
         m_on       = 1'b1;
         m_last_rx  = 1'b0;
         m_rx_valid = 1'b0;
         m_hwrite   = 1'b0;
         m_err      = 1'b0;
         m_err_s    = 1'b0;
         m_rx_data  = 8'h00;
         m_tx_byte  = 8'h00;
         m_haddr    = 32'h0;
         m_hwdata   = 32'h0;
         m_tx_cnt   = 16'h0;
         m_rx_cnt   = 16'h0;
         m_spur     = 16'h0;
         m_stall    = 0;
      end else begin
         rv_next = m_rx_valid;
         if (m_rx_valid && rx_ready) rv_next = 1'b0;
         if (m_q.size() != 0 && !hready) begin
            m_stall = m_stall + 1;
            if (m_stall >= 4)    m_err_s = 1'b1;
            if (m_stall >= 1024) m_err   = 1'b1;
         end else begin
            m_stall = 0;
         end
         if (m_q.size() == 0) begin
            rxr = irq && !m_rx_valid;
            txr = tx_valid;
            if (rxr && !(txr && m_last_rx)) begin
               m_q.push_back(P_SA);
               m_q.push_back(P_SD);
               m_last_rx = 1'b1;
               m_haddr   = 32'h4;
               m_hwrite  = 1'b0;
            end else if (txr) begin
               m_q.push_back(P_WA);
               m_q.push_back(P_WD);
               m_tx_byte = tx_data;
               m_last_rx = 1'b0;
               m_haddr   = 32'h0;
               m_hwrite  = 1'b1;
            end
         end else if (hready) begin
            ph = m_q.pop_front();
            case (ph)
               P_WA: m_hwdata = {24'h0, m_tx_byte};
               P_WD: m_tx_cnt = m_tx_cnt + 16'h1;
               P_SD: begin
                  if (stat_word[0]) begin
                     m_spur = m_spur + 16'h1;
                  end else begin
                     m_q.push_back(P_RA);
                     m_q.push_back(P_RD);
                     m_haddr  = 32'h0;
                     m_hwrite = 1'b0;
                  end
               end
               P_RD: begin
                  m_rx_data = data_word[7:0];
                  rv_next   = 1'b1;
                  m_rx_cnt  = m_rx_cnt + 16'h1;
               end
               default: ;
            endcase
         end
         m_rx_valid = rv_next;
      end
   end

   // Compare every output against the model mid-cycle, away from the active edge.
   always @(negedge clk) begin : compare
      logic addr_ph;
      logic exp_rdy;
      if (m_on) begin
         addr_ph = (m_q.size() != 0) && (m_q[0] == P_WA || m_q[0] == P_SA || m_q[0] == P_RA);
         exp_rdy = (m_q.size() == 0) && tx_valid && (!(irq && !m_rx_valid) || m_last_rx);
         check_output("HTRANS",      {30'h0, ahb.HTRANS}, addr_ph ? 32'h2 : 32'h0);
         check_output("HSEL",        {31'h0, ahb.HSEL},   {31'h0, addr_ph});
         check_output("HWRITE",      {31'h0, ahb.HWRITE}, {31'h0, m_hwrite});
         check_output("HADDR",       ahb.HADDR,           m_haddr);
         check_output("HWDATA",      ahb.HWDATA,          m_hwdata);
         check_output("tx_ready",    {31'h0, tx_ready},   {31'h0, exp_rdy});
         check_output("rx_valid",    {31'h0, rx_valid},   {31'h0, m_rx_valid});
         check_output("rx_data",     {24'h0, rx_data},    {24'h0, m_rx_data});
         check_output("tx_count",    {16'h0, tx_count},   {16'h0, m_tx_cnt});
         check_output("rx_count",    {16'h0, rx_count},   {16'h0, m_rx_cnt});
         check_output("spurious",    {16'h0, spurious},   {16'h0, m_spur});
         check_output("stall_err",   {31'h0, stall_err},  {31'h0, m_err});
         check_output("stall_err_s", {31'h0, stall_err_s},{31'h0, m_err_s});
         check_output("busy",        {31'h0, busy},       {31'h0, (m_q.size() != 0)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic v_irq, input logic v_txv, input logic [7:0] v_txd,
                                 input logic v_rxr);
      irq      = v_irq;
      tx_valid = v_txv;
      tx_data  = v_txd;
      rx_ready = v_rxr;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      hready    = 1'b1;
      stat_word = 32'h0;
      data_word = 32'h0;
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      check_output("reset_HTRANS", {30'h0, ahb.HTRANS}, 32'h0);
      check_output("reset_HWDATA", ahb.HWDATA, 32'h0);
      check_output("reset_busy",   {31'h0, busy}, 32'h0);

      // Single TX byte with zero wait states
      apply_stimulus(1'b0, 1'b1, 8'hA5, 1'b0);
      #1;
      check_output("tx_ready_grant", {31'h0, tx_ready}, 32'h1);
      tick();
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      check_output("wr_a_HTRANS", {30'h0, ahb.HTRANS}, 32'h2);
      check_output("wr_a_HWRITE", {31'h0, ahb.HWRITE}, 32'h1);
      check_output("wr_a_HADDR",  ahb.HADDR, 32'h0);
      tick();
      check_output("wr_d_HWDATA", ahb.HWDATA, 32'h0000_00A5);
      tick();
      check_output("tx_count_1",  {16'h0, tx_count}, 32'h1);

      // TX with five wait states in the data phase
      apply_stimulus(1'b0, 1'b1, 8'h3C, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      hready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_output("stall_HWDATA", ahb.HWDATA, 32'h0000_003C);
         tick();
      end
      hready = 1'b1;
      check_output("stall_busy",      {31'h0, busy}, 32'h1);
      check_output("stall_err_1024",  {31'h0, stall_err}, 32'h0);
      check_output("stall_err_lim4",  {31'h0, stall_err_s}, 32'h1);
      tick();
      check_output("stall_tx_count",  {16'h0, tx_count}, 32'h2);
      check_output("stall_err_stick", {31'h0, stall_err_s}, 32'h1);

      // RX with an empty-flag-clear status and data 0x42
      reset_dut();
      stat_word = 32'h0;
      data_word = 32'h0000_0042;
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      check_output("st_a_HADDR",  ahb.HADDR, 32'h4);
      check_output("st_a_HWRITE", {31'h0, ahb.HWRITE}, 32'h0);
      tick();
      tick();
      check_output("rd_a_HTRANS", {30'h0, ahb.HTRANS}, 32'h2);
      check_output("rd_a_HADDR",  ahb.HADDR, 32'h0);
      tick();
      tick();
      check_output("rx_valid_c5", {31'h0, rx_valid}, 32'h1);
      check_output("rx_data_c5",  {24'h0, rx_data}, 32'h42);
      check_output("rx_count_1",  {16'h0, rx_count}, 32'h1);
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      check_output("rx_valid_drop", {31'h0, rx_valid}, 32'h0);
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

      // Spurious interrupt: status reports rx_empty
      stat_word = 32'h1;
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      check_output("spur_busy",  {31'h0, busy}, 32'h0);
      check_output("spur_count", {16'h0, spurious}, 32'h1);
      check_output("spur_HADDR", ahb.HADDR, 32'h4);

      // Contention: RX and TX alternate, RX first
      reset_dut();
      stat_word = 32'h0;
      for (int i = 0; i < 80; i++) begin
         data_word = 32'h80 + 32'(i);
         apply_stimulus(1'b1, 1'b1, 8'(8'h10 + i), 1'b1);
         if (i == 1) check_output("contend_first_rx", ahb.HADDR, 32'h4);
         if (i == 6) check_output("contend_then_tx", {31'h0, ahb.HWRITE}, 32'h1);
         tick();
      end
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      check_output("contend_tx_count", {16'h0, tx_count}, 32'd10);
      check_output("contend_rx_count", {16'h0, rx_count}, 32'd10);

      // Backpressure: consumer never takes the byte
      reset_dut();
      data_word = 32'h0000_005A;
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
      repeat (20) tick();
      check_output("bp_rx_valid", {31'h0, rx_valid}, 32'h1);
      check_output("bp_rx_data",  {24'h0, rx_data}, 32'h5A);
      check_output("bp_rx_count", {16'h0, rx_count}, 32'h1);
      check_output("bp_HTRANS",   {30'h0, ahb.HTRANS}, 32'h0);

      // Reset while the data-register address phase is on the bus
      reset_dut();
      tick();
      tick();
      tick();
      check_output("pre_rst_HTRANS", {30'h0, ahb.HTRANS}, 32'h2);
      reset_dut();
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      check_output("rst_HTRANS",   {30'h0, ahb.HTRANS}, 32'h0);
      check_output("rst_HSEL",     {31'h0, ahb.HSEL}, 32'h0);
      check_output("rst_HADDR",    ahb.HADDR, 32'h0);
      check_output("rst_busy",     {31'h0, busy}, 32'h0);
      check_output("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
      tick();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
